parking_ticket_arbiter: RTL and testbench
=========================================

Name: parking_ticket_arbiter

Overview:
- Shares one ticket printer among NUM_LANES quarter-operated parking pay stations.
- Each pay station FSM emits a one-cycle ticket pulse. This block queues the pulses per lane as pending counts.
- Grants the printer round-robin and sequences each print job: start pulse, fixed busy window, return to idle.
- Sits between the per-lane pay-station FSMs and the shared printer driver.

Parameters:
- NUM_LANES, 4, number of pay-station lanes; legal range 2..8.
- PRINT_CYCLES, 8, cycles the printer is held busy per ticket; must be >= 2.
- MAX_PENDING, 3, per-lane saturation limit of queued tickets; must be >= 1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ticket_req  in  NUM_LANES  per-lane one-cycle ticket pulse from the pay-station FSMs.
- printer_ready  in  1  printer driver can accept a job; sampled only in IDLE.
- print_start  out  1  one-cycle pulse launching a print job.
- print_lane  out  $clog2(NUM_LANES)  lane index of the current job; valid from print_start through end of PRINT.
- print_busy  out  1  high during ISSUE and PRINT.
- lane_full  out  NUM_LANES  per-lane flag, high while that lane's pending count == MAX_PENDING.
- drop_pulse  out  NUM_LANES  one-cycle flag: a request on that lane was discarded at saturation.
- tickets_issued  out  16  count of print_start pulses; wraps 0xFFFF -> 0x0000.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; all pending counts 0; round-robin pointer last_grant = NUM_LANES-1, so lane 0 has first priority.
- Pending counter per lane, width $clog2(MAX_PENDING+1):
  - ticket_req[i] alone -> count+1.
  - Grant to lane i alone -> count-1.
  - Both in the same cycle -> count unchanged; no drop.
  - ticket_req[i] with count == MAX_PENDING and no same-cycle grant -> count stays; drop_pulse[i]=1 next cycle.
  - Simultaneous requests on several lanes are all accepted independently.
- lane_full is registered. It reflects the count after the update.
- FSM states IDLE, ISSUE, PRINT:
  - IDLE: if printer_ready=1 and any count>0, grant the first lane with count>0 searching last_grant+1, last_grant+2, ... (mod NUM_LANES).
    - On a grant: decrement that count, register print_lane, update last_grant, go to ISSUE.
    - Otherwise stay in IDLE.
    - A request arriving in the same cycle is not visible for arbitration until the next cycle.
  - ISSUE, 1 cycle: print_start=1, print_busy=1, tickets_issued+1. Load the down-counter with PRINT_CYCLES-1. Go to PRINT.
  - PRINT: print_busy=1. Decrement the down-counter. When it reaches 0, go to IDLE.
    - Busy window from print_start to return to IDLE is exactly PRINT_CYCLES cycles.
    - print_lane holds its value during PRINT and retains it in IDLE.
- Latency: a request into an idle, empty arbiter with printer_ready=1 gives print_start 2 cycles after the ticket_req cycle (count update, then grant).
- Back-to-back: one job per PRINT_CYCLES+1 cycles minimum, because IDLE lasts at least 1 cycle between jobs.
- printer_ready is ignored outside IDLE. Its deassertion mid-PRINT does not abort the job.
- Asynchronous reset mid-operation: immediate return to reset values.
  - Pending counts are lost.
  - print_busy drops asynchronously.
  - No print_start is emitted on reset release.
- Requests during ISSUE/PRINT still queue normally.

Test Plan:
- Reset, then a single pulse on lane 2 at cycle 10 with printer_ready=1 -> print_start at cycle 12, print_lane=2, print_busy high cycles 12..19 (PRINT_CYCLES=8), tickets_issued=1.
- One pulse on each of lanes 0..3 in the same cycle -> grants in order 0,1,2,3, print_start 9 cycles apart, tickets_issued=4, all counts 0 at end.
- 5 pulses on lane 1 while printer_ready=0 -> count saturates at 3, lane_full[1]=1, drop_pulse[1] asserted twice, no print_start. Then printer_ready=1 -> exactly 3 jobs on lane 1.
- Lane 3 pulse in the same cycle as a grant to lane 3 at count 3 -> count stays 3, no drop_pulse.
- Round-robin fairness: lanes 0 and 1 each hold 3 pending -> grant order 0,1,0,1,0,1.
- Assert reset_n low during cycle 4 of PRINT with 2 pending on lane 0 -> print_busy=0 immediately, counts 0, tickets_issued=0, and no job after release without new requests.
- Preload tickets_issued to 0xFFFF via 65535 jobs (or a forced value) -> one more job wraps it to 0x0000.

Source files
------------

// File: rtl/parking_ticket_arbiter.sv
// Shares one ticket printer among NUM_LANES pay stations: per-lane pending
// counters, round-robin grant, and an IDLE/ISSUE/PRINT job sequencer.
module parking_ticket_arbiter #(
    parameter int NUM_LANES    = 4,
    parameter int PRINT_CYCLES = 8,
    parameter int MAX_PENDING  = 3
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_LANES-1:0]         ticket_req,
    input  logic                         printer_ready,
    output logic                         print_start,
    output logic [$clog2(NUM_LANES)-1:0] print_lane,
    output logic                         print_busy,
    output logic [NUM_LANES-1:0]         lane_full,
    output logic [NUM_LANES-1:0]         drop_pulse,
    output logic [15:0]                  tickets_issued
);
    localparam int LW = $clog2(NUM_LANES);
    localparam int CW = $clog2(MAX_PENDING + 1);
    localparam int DW = $clog2(PRINT_CYCLES);
    localparam logic [CW-1:0] CNT_MAX   = CW'(MAX_PENDING);
    localparam logic [DW-1:0] DOWN_LOAD = DW'(PRINT_CYCLES - 1);
    localparam logic [LW-1:0] LAST_LANE = LW'(NUM_LANES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, PRINT} state_t;

    state_t               state, state_nxt;
    logic [DW-1:0]        down_cnt;
    logic [LW-1:0]        last_grant, grant_lane;
    logic [LW:0]          arb_sum;
    logic                 grant_found, grant;
    logic [NUM_LANES-1:0] grant_vec, drop_nxt, full_nxt;
    logic [CW-1:0]        pending     [NUM_LANES];
    logic [CW-1:0]        pending_nxt [NUM_LANES];

    // Round-robin search starting one past the last granted lane.
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        grant_found = 1'b0;
        grant_lane  = '0;
        arb_sum     = '0;
        for (int k = 1; k <= NUM_LANES; k++) begin
            arb_sum = {1'b0, last_grant} + (LW + 1)'(k);
            if (arb_sum >= (LW + 1)'(NUM_LANES))
                arb_sum = arb_sum - (LW + 1)'(NUM_LANES);
            if (!grant_found && pending[arb_sum[LW-1:0]] != '0) begin
                grant_found = 1'b1;
                grant_lane  = arb_sum[LW-1:0];
            end
        end
        grant     = (state == IDLE) && printer_ready && grant_found;
        grant_vec = grant ? (NUM_LANES'(1) << grant_lane) : '0;
    end

    // A same-cycle request and grant cancel; a request at saturation is dropped.
    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            pending_nxt[i] = pending[i];
            drop_nxt[i]    = 1'b0;
            if (ticket_req[i] && !grant_vec[i]) begin
                if (pending[i] == CNT_MAX)
                    drop_nxt[i] = 1'b1;
                else
                    pending_nxt[i] = pending[i] + CW'(1);
            end else if (grant_vec[i] && !ticket_req[i]) begin
                pending_nxt[i] = pending[i] - CW'(1);
            end
            full_nxt[i] = (pending_nxt[i] == CNT_MAX);
        end
    end

    // NOTE: pending counts are a handful of flops, so they are reset like any other state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_LANES; i++) pending[i] <= '0;
            lane_full  <= '0;
            drop_pulse <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            for (int i = 0; i < NUM_LANES; i++) pending[i] <= pending_nxt[i];
            lane_full  <= full_nxt;
            drop_pulse <= drop_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        print_start = 1'b0;
        print_busy  = 1'b0;
        case (state)
            IDLE: begin
                if (grant) state_nxt = ISSUE;
            end
            ISSUE: begin
                print_start = 1'b1;
                print_busy  = 1'b1;
                state_nxt   = PRINT;
            end
            PRINT: begin
                print_busy = 1'b1;
                if (down_cnt == DW'(1)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ISSUE plus PRINT_CYCLES-1 PRINT cycles give the full busy window.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            down_cnt       <= '0;
            print_lane     <= '0;
            last_grant     <= LAST_LANE;
            tickets_issued <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                print_lane <= grant_lane;
                last_grant <= grant_lane;
            end
            if (state == ISSUE) begin
                down_cnt       <= DOWN_LOAD;
                tickets_issued <= tickets_issued + 16'd1;
            end else if (state == PRINT) begin
                down_cnt <= down_cnt - DW'(1);
            end
        end
    end

endmodule

// File: tb/tb_parking_ticket_arbiter.sv
// Directed bench for parking_ticket_arbiter with hand-computed expectations.
module tb_parking_ticket_arbiter;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [N-1:0] ticket_req = '0;
    logic         printer_ready = 1'b0;
    logic         print_start;
    logic [1:0]   print_lane;
    logic         print_busy;
    logic [N-1:0] lane_full;
    logic [N-1:0] drop_pulse;
    logic [15:0]  tickets_issued;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int busy_cnt = 0;
    int start_lane[$];
    int start_cyc[$];
    int drop_cnt[N];
    int s0, b0, c0;
    int d0[N];

    parking_ticket_arbiter #(.NUM_LANES(4), .PRINT_CYCLES(8), .MAX_PENDING(3)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ticket_req     (ticket_req),
        .printer_ready  (printer_ready),
        .print_start    (print_start),
        .print_lane     (print_lane),
        .print_busy     (print_busy),
        .lane_full      (lane_full),
        .drop_pulse     (drop_pulse),
        .tickets_issued (tickets_issued)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial for (int i = 0; i < N; i++) drop_cnt[i] = 0;

    always @(negedge clk) begin
        if (reset_n) begin
            if (print_start) begin
                start_lane.push_back(int'(print_lane));
                start_cyc.push_back(cyc);
            end
            if (print_busy) busy_cnt = busy_cnt + 1;
            for (int i = 0; i < N; i++)
                if (drop_pulse[i]) drop_cnt[i] = drop_cnt[i] + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic mark();
        s0 = start_lane.size();
        b0 = busy_cnt;
        for (int i = 0; i < N; i++) d0[i] = drop_cnt[i];
    endtask

    function automatic int n_starts();
        return start_lane.size() - s0;
    endfunction

    function automatic int lane_at(input int i);
        return (s0 + i < start_lane.size()) ? start_lane[s0 + i] : -1;
    endfunction

    function automatic int cyc_at(input int i);
        return (s0 + i < start_cyc.size()) ? start_cyc[s0 + i] : -1000;
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n       = 1'b0;
        ticket_req    = '0;
        printer_ready = 1'b0;
        step(2);
        reset_n = 1'b1;
        step(1);
    endtask

    task automatic pulse(input logic [N-1:0] v, input int n);
        repeat (n) begin
            ticket_req = v;
            @(negedge clk);
        end
        ticket_req = '0;
    endtask

    initial begin
        // Reset values
        do_reset();
        check("rst_start", print_start, 0);
        check("rst_busy", print_busy, 0);
        check("rst_lane", print_lane, 0);
        check("rst_full", lane_full, 0);
        check("rst_drop", drop_pulse, 0);
        check("rst_issued", tickets_issued, 0);

        // Single request on lane 2: start two cycles later, 8 busy cycles
        printer_ready = 1'b1;
        mark();
        c0 = cyc;
        pulse(4'b0100, 1);
        step(25);
        check("t1_starts", n_starts(), 1);
        check("t1_lane", lane_at(0), 2);
        check("t1_latency", cyc_at(0) - c0, 2);
        check("t1_busy_len", busy_cnt - b0, 8);
        check("t1_issued", tickets_issued, 1);
        check("t1_lane_hold", print_lane, 2);
        check("t1_idle", print_busy, 0);

        // All four lanes at once: in-order grants, 9 cycles apart
        do_reset();
        printer_ready = 1'b1;
        mark();
        pulse(4'b1111, 1);
        step(45);
        check("t2_starts", n_starts(), 4);
        for (int i = 0; i < 4; i++) check($sformatf("t2_lane%0d", i), lane_at(i), i);
        for (int i = 1; i < 4; i++) check($sformatf("t2_gap%0d", i), cyc_at(i) - cyc_at(i - 1), 9);
        check("t2_issued", tickets_issued, 4);
        check("t2_full", lane_full, 0);

        // Saturation on lane 1 with the printer not ready
        do_reset();
        mark();
        pulse(4'b0010, 5);
        step(1);
        check("t3_full", lane_full, 4'b0010);
        check("t3_drops", drop_cnt[1] - d0[1], 2);
        check("t3_no_start", n_starts(), 0);
        printer_ready = 1'b1;
        step(35);
        check("t3_starts", n_starts(), 3);
        for (int i = 0; i < 3; i++) check($sformatf("t3_lane%0d", i), lane_at(i), 1);
        check("t3_full_clr", lane_full, 0);
        check("t3_drops_end", drop_cnt[1] - d0[1], 2);

        // Request and grant on lane 3 in the same cycle at saturation
        do_reset();
        mark();
        pulse(4'b1000, 3);
        check("t4_full_pre", lane_full, 4'b1000);
        printer_ready = 1'b1;
        ticket_req    = 4'b1000;
        step(1);
        ticket_req    = '0;
        printer_ready = 1'b0;
        check("t4_start", print_start, 1);
        check("t4_lane", print_lane, 3);
        check("t4_full_hold", lane_full, 4'b1000);
        check("t4_no_drop", drop_pulse, 0);
        step(10);
        printer_ready = 1'b1;
        step(35);
        check("t4_starts", n_starts(), 4);
        check("t4_drops", drop_cnt[3] - d0[3], 0);
        check("t4_issued", tickets_issued, 4);

        // Round-robin between lanes 0 and 1
        do_reset();
        mark();
        pulse(4'b0011, 3);
        printer_ready = 1'b1;
        step(60);
        check("t5_starts", n_starts(), 6);
        for (int i = 0; i < 6; i++) check($sformatf("t5_lane%0d", i), lane_at(i), i % 2);

        // Asynchronous reset in the middle of PRINT
        do_reset();
        pulse(4'b0001, 3);
        printer_ready = 1'b1;
        step(1);
        printer_ready = 1'b0;
        check("t6_start", print_start, 1);
        step(4);
        check("t6_busy_pre", print_busy, 1);
        check("t6_full_pre", lane_full, 0);
        #2 reset_n = 1'b0;
        #1;
        check("t6_busy_async", print_busy, 0);
        check("t6_issued_clr", tickets_issued, 0);
        check("t6_start_clr", print_start, 0);
        step(1);
        reset_n       = 1'b1;
        printer_ready = 1'b1;
        mark();
        step(20);
        check("t6_no_job", n_starts(), 0);
        check("t6_issued", tickets_issued, 0);

        // tickets_issued wraps from 0xFFFF to 0
        do_reset();
        printer_ready = 1'b1;
        force dut.tickets_issued = 16'hFFFF;
        step(1);
        release dut.tickets_issued;
        step(1);
        check("t7_preload", tickets_issued, 16'hFFFF);
        pulse(4'b0001, 1);
        step(1);
        check("t7_issue", print_start, 1);
        step(1);
        check("t7_wrap", tickets_issued, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
